// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then shifts out one
// command byte on device clock falling edges and samples the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2000,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       done,
  output logic       nack,
  output logic       timeout
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FILT_LAST    = FLT_W'(FILTER_LEN - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] ACK       = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [1:0]       clk_sync_r;
  logic [1:0]       data_sync_r;
  logic             clk_s;
  logic             data_s;
  logic             filt_clk_r;
  logic             filt_prev_r;
  logic [FLT_W-1:0] filt_cnt_r;
  logic             fall_s;

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bit_idx_r;
  logic [7:0]       data_r;
  logic             bit_s;
  logic             tx_ready_r;
  logic             clk_low_r;
  logic             data_low_r;
  logic             done_r;
  logic             nack_r;
  logic             timeout_r;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  assign clk_s  = clk_sync_r[1];
  assign data_s = data_sync_r[1];
  assign fall_s = filt_prev_r & ~filt_clk_r;

  // Two-stage synchronizers for both raw PS/2 lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= 2'b00;
      data_sync_r <= 2'b00;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk_in};
      data_sync_r <= {data_sync_r[0], ps2_data_in};
    end
  end

  // Clock filter: accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_s != filt_clk_r) begin
        if (filt_cnt_r == FILT_LAST) begin
          filt_clk_r <= clk_s;
          filt_cnt_r <= '0;
        end else begin
          filt_cnt_r <= filt_cnt_r + FLT_W'(1);
        end
      end else begin
        filt_cnt_r <= '0;
      end
    end
  end

  // Frame bit for the current index: D0..D7, odd parity, then stop.
  always_comb begin
    bit_s = 1'b1;
    case (bit_idx_r)
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: bit_s = data_r[bit_idx_r[2:0]];
      4'd8:                   bit_s = odd_parity(data_r);
      default:                bit_s = 1'b1;
    endcase
  end

  // Transfer sequencer; any expiry of cnt_r while waiting on the device aborts the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_idx_r  <= 4'd0;
      data_r     <= 8'd0;
      tx_ready_r <= 1'b1;
      clk_low_r  <= 1'b0;
      data_low_r <= 1'b0;
      done_r     <= 1'b0;
      nack_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          clk_low_r  <= 1'b0;
          data_low_r <= 1'b0;
          if (tx_valid && tx_ready_r) begin
            data_r     <= tx_data;
            nack_r     <= 1'b0;
            timeout_r  <= 1'b0;
            tx_ready_r <= 1'b0;
            clk_low_r  <= 1'b1;
            cnt_r      <= '0;
            state_r    <= INHIBIT;
          end else begin
            tx_ready_r <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt_r == INHIBIT_LAST) begin
            data_low_r <= 1'b1;
            cnt_r      <= '0;
            state_r    <= START;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        START: begin
          clk_low_r <= 1'b0;
          bit_idx_r <= 4'd0;
          cnt_r     <= '0;
          state_r   <= SEND;
        end
        SEND, ACK: begin
          if (fall_s) begin
            cnt_r <= '0;
            if (state_r == ACK) begin
              nack_r  <= data_s;
              state_r <= WAIT_IDLE;
            end else begin
              data_low_r <= ~bit_s;
              bit_idx_r  <= bit_idx_r + 4'd1;
              if (bit_idx_r == 4'd9) begin
                state_r <= ACK;
              end else begin
                state_r <= SEND;
              end
            end
          end else if (cnt_r == TIMEOUT_LAST) begin
            clk_low_r  <= 1'b0;
            data_low_r <= 1'b0;
            timeout_r  <= 1'b1;
            done_r     <= 1'b1;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (filt_clk_r && data_s) begin
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            timeout_r <= 1'b1;
            done_r    <= 1'b1;
            state_r   <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          clk_low_r  <= 1'b0;
          data_low_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready           = tx_ready_r;
  assign ps2_clk_drive_low  = clk_low_r;
  assign ps2_data_drive_low = data_low_r;
  assign done               = done_r;
  assign nack               = nack_r;
  assign timeout            = timeout_r;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have these parameters:
- INHIBIT_CYCLES, 2000, clk cycles the host holds PS/2 clock low before a transfer (100 us at 20 MHz).
- TIMEOUT_CYCLES, 40000, maximum clk cycles allowed between device clock falling edges.
- FILTER_LEN, 8, consecutive identical synchronized samples needed to accept a new ps2_clk level.

REQ-002 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high reset.
- tx_valid, in, 1, request to send tx_data.
- tx_data, in, 8, command byte to send.
- tx_ready, out, 1, block idle and able to accept a byte.
- ps2_clk_in, in, 1, raw PS/2 clock line.
- ps2_data_in, in, 1, raw PS/2 data line.
- ps2_clk_drive_low, out, 1, 1 = pull PS/2 clock low; 0 = release it.
- ps2_data_drive_low, out, 1, 1 = pull PS/2 data low; 0 = release it.
- done, out, 1, one-cycle pulse when a transfer ends.
- nack, out, 1, no acknowledge from the device; valid from the done pulse until the next accept.
- timeout, out, 1, transfer was aborted; valid from the done pulse until the next accept.

Function
REQ-003 Clock reset is decided: reset is asynchronous and active-high; clk is the clock.
REQ-004 Input sampling: ps2_clk_in and ps2_data_in SHALL each pass through a 2-FF synchronizer; all logic uses only the synchronized versions.
REQ-005 Clock filter: the filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples that differ from the current filtered level.
REQ-006 Falling edge: a falling edge is a filtered-clock 1->0 transition; at most one edge is recognized per cycle.
REQ-007 Handshake: tx_valid and tx_ready both high in the same cycle SHALL latch tx_data, clear nack and timeout, and drop tx_ready on the next cycle.
REQ-008 tx_valid while tx_ready is low SHALL be ignored, with no queuing.
REQ-009 States SHALL be IDLE, INHIBIT, START, SEND, ACK and WAIT_IDLE.
REQ-010 IDLE: tx_ready=1 and both drive outputs 0; an accept moves to INHIBIT.
REQ-011 INHIBIT: ps2_clk_drive_low=1 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-012 START: ps2_data_drive_low=1 with ps2_clk_drive_low still 1 for 1 cycle; then release clock (ps2_clk_drive_low=0), keep data low, enter SEND, and clear the bit index and timeout counter.
REQ-013 SEND: on falling edges 1-10, drive the next bit in this order: D0..D7 (LSB first), odd parity (~^tx_data), then stop.
REQ-014 Bit driving: ps2_data_drive_low = ~bit; stop is bit value 1, so data is released.
REQ-015 After the 10th edge, go to ACK.
REQ-016 ACK: on the 11th falling edge, sample synchronized data; 0 means acknowledge, 1 sets nack.
REQ-017 After the ACK sample, go to WAIT_IDLE.
REQ-018 WAIT_IDLE: wait until filtered clock=1 and synchronized data=1 on the same cycle; then pulse done and return to IDLE.
REQ-019 Timeout counting: from clock release until leaving ACK, count cycles since the last falling edge; the counter is reset on each edge.
REQ-020 Timeout in SEND/ACK: when the count reaches TIMEOUT_CYCLES, release both lines, set timeout=1, pulse done and go to IDLE.
REQ-021 Timeout in WAIT_IDLE: use the same TIMEOUT_CYCLES limit; expiry sets timeout, pulses done and goes to IDLE.
REQ-022 No falling edges are counted during INHIBIT or START.
REQ-023 done SHALL never assert on the same cycle as tx_ready rising earlier than the return to IDLE; tx_ready rises on the cycle after done.

Reset
REQ-024 During reset, the following SHALL be held at 0: all outputs except tx_ready, the synchronizers, the filter and all counters.
REQ-025 During reset, tx_ready=1, the filtered clock=1 and state=IDLE.
REQ-026 Reset asserted mid-transfer SHALL release both lines immediately (asynchronously) with no done pulse.

Verification
REQ-027 Acknowledged transfer: send 0xED with a device model that acks.
- Observed bit sequence: 1,0,1,1,0,1,1,1, parity 1, stop 1.
- Exactly one done pulse; nack=0, timeout=0.
REQ-028 Parity: send 0x01 -> parity bit 0; send 0x00 -> parity bit 1; both acked, nack=0.
REQ-029 No acknowledge: the device leaves data high on the 11th edge -> done pulses with nack=1, timeout=0, then tx_ready=1.
REQ-030 Dead device: the device never clocks after release.
- After TIMEOUT_CYCLES (use 200 in the bench): timeout=1, done pulse.
- Both drive outputs 0.
REQ-031 Glitch rejection: a 3-cycle low glitch on ps2_clk_in with FILTER_LEN=8 during SEND -> bit index unchanged, ps2_data_drive_low unchanged.
REQ-032 Reset mid-SEND after the 4th edge:
- Both drive outputs 0 in the same cycle, tx_ready=1, no done.
- A following 0xAA transfer then completes correctly.
